aes_block_buffer: RTL

- Sits between the HWPE streamers and the AES-128 cipher core, directly downstream of the plaintext source and upstream of the ciphertext sink.
- Assembles four 32-bit plaintext stream words into one 128-bit block for the core.
- Serialises the 128-bit ciphertext block from the core back into four 32-bit words for the sink.
- Two independent buffer halves (pack, unpack), each with its own 2-bit word counter and small FSM.

---
 rtl/aes_block_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/aes_block_buffer.sv
// Packs four 32-bit plaintext words into a 128-bit AES block and unpacks a 128-bit ciphertext block into four words.
// Optional macro AES_BYTE_SWAP_EN reverses the byte order inside every 32-bit word on both paths.
module aes_block_buffer #(
  parameter  int WORD_W        = 32,
  parameter  int WORDS_PER_BLK = 4,
  localparam int BLK_W         = WORD_W * WORDS_PER_BLK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [WORD_W-1:0] pt_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [BLK_W-1:0]  ct_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        pack_cnt,
  output logic [1:0]        unpack_cnt,
  output logic              blk_done
);

  typedef enum logic {P_FILL, P_FULL} pack_state_t;
  typedef enum logic {U_EMPTY, U_DRAIN} unpack_state_t;

  pack_state_t   pack_state;
  unpack_state_t unpack_state;
  logic [BLK_W-1:0] ct_buf;

  // Little-endian memory words become AES big-endian byte order when the swap is enabled.
  function automatic logic [WORD_W-1:0] byte_order(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
`ifdef AES_BYTE_SWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    end
`endif
    return r;
  endfunction

  // Ready flags stay low during reset and come up on the first clock afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_state <= P_FILL;
      pack_cnt   <= 2'd0;
      blk_data   <= '0;
      pt_ready   <= 1'b0;
      blk_valid  <= 1'b0;
    end else if (clear) begin
      pack_state <= P_FILL;
      pack_cnt   <= 2'd0;
      blk_data   <= '0;
      pt_ready   <= 1'b1;
      blk_valid  <= 1'b0;
    end else begin
      case (pack_state)
        P_FILL: begin
          pt_ready <= 1'b1;
          if (pt_valid && pt_ready) begin
            blk_data[(WORDS_PER_BLK-1-int'(pack_cnt))*WORD_W +: WORD_W] <= byte_order(pt_data);
            pack_cnt <= pack_cnt + 2'd1;
            if (pack_cnt == 2'd3) begin
              pack_state <= P_FULL;
              pt_ready   <= 1'b0;
              blk_valid  <= 1'b1;
            end
          end
        end
        P_FULL: begin
          if (blk_ready) begin
            pack_state <= P_FILL;
            blk_valid  <= 1'b0;
            pt_ready   <= 1'b1;
          end
        end
        default: pack_state <= P_FILL;
      endcase
    end
  end

  // Unpack half: hold one ciphertext block and hand it out a word at a time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unpack_state <= U_EMPTY;
      unpack_cnt   <= 2'd0;
      ct_buf       <= '0;
      ct_ready     <= 1'b0;
      out_valid    <= 1'b0;
      blk_done     <= 1'b0;
    end else if (clear) begin
      unpack_state <= U_EMPTY;
      unpack_cnt   <= 2'd0;
      ct_buf       <= '0;
      ct_ready     <= 1'b1;
      out_valid    <= 1'b0;
      blk_done     <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (unpack_state)
        U_EMPTY: begin
          ct_ready <= 1'b1;
          if (ct_valid && ct_ready) begin
            ct_buf       <= ct_data;
            unpack_cnt   <= 2'd0;
            unpack_state <= U_DRAIN;
            ct_ready     <= 1'b0;
            out_valid    <= 1'b1;
          end
        end
        U_DRAIN: begin
          if (out_ready) begin
            unpack_cnt <= unpack_cnt + 2'd1;
            if (unpack_cnt == 2'd3) begin
              unpack_state <= U_EMPTY;
              out_valid    <= 1'b0;
              ct_ready     <= 1'b1;
              blk_done     <= 1'b1;
            end
          end
        end
        default: unpack_state <= U_EMPTY;
      endcase
    end
  end

  assign out_data = byte_order(ct_buf[(WORDS_PER_BLK-1-int'(unpack_cnt))*WORD_W +: WORD_W]);

endmodule
